game_sequencer: RTL and testbench

//  Top-level game-flow controller for the brick breaker: sequences attract, serve, play, pause
//  and end-of-game phases on top of the VGA sync counters. Generates the once-per-frame update

---
 rtl/game_sequencer_pkg.sv | 27 ++
 rtl/btn_edge_sync.sv | 36 +++
 rtl/game_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : game_sequencer_pkg                                     |
// | Brief   : Shared game-phase encodings and helpers for the brick  |
// |           breaker flow controller and the banner renderer.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package game_sequencer_pkg;

  localparam int STATE_W = 3;

  // Phase encodings are also used by the renderer to select banner text
  typedef enum logic [STATE_W-1:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_WON     = 3'd4,
    ST_LOST    = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : btn_edge_sync                                          |
// | Brief   : Two-flop synchronizer for an asynchronous button plus  |
// |           a one-cycle rising-edge pulse.                         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Metastability filter followed by a history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // A held button produces exactly one pulse
  assign o_pulse = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : game_sequencer                                         |
// | Brief   : Brick breaker game-flow FSM: attract, serve, play,     |
// |           pause, won/lost. Frame strobe, ball/brick control,     |
// |           lives and saturating score.                            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int FRAME_LINE   = 500,
  parameter int LIVES_INIT   = 3,
  parameter int NUM_BRICKS   = 40,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         counter_x,
  input  logic [8:0]         counter_y,
  input  logic               btn_start,
  input  logic               ball_lost,
  input  logic               brick_hit,
  output logic               frame_tick,
  output logic               move_en,
  output logic               ball_reset,
  output logic               bricks_reset,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score
);

  localparam int FCNT_W  = $clog2(max_int(SERVE_FRAMES, OVER_FRAMES) + 1);
  localparam int BRICK_W = $clog2(NUM_BRICKS + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_frame_tick;
  logic                 r_bricks_reset;
  logic                 w_bricks_reset_nxt;
  logic [1:0]           r_lives;
  logic [1:0]           w_lives_nxt;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [BRICK_W-1:0]   r_bricks_left;
  logic [BRICK_W-1:0]   w_bricks_nxt;
  logic [FCNT_W-1:0]    r_frame_cnt;
  logic [FCNT_W-1:0]    w_fcnt_nxt;
  logic                 w_ball_reset;
  logic                 w_start_ev;

  btn_edge_sync u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btn_start),
    .o_pulse (w_start_ev)
  );

  // Frame strobe: one cycle after the raster reaches the chosen line start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= (counter_x == 10'd0) && (counter_y == 9'(FRAME_LINE));
    end
  end

  // Phase register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ATTRACT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next phase plus lives/score/bricks/frame-count updates
  always_comb begin
    w_state_nxt        = r_state;
    w_lives_nxt        = r_lives;
    w_score_nxt        = r_score;
    w_bricks_nxt       = r_bricks_left;
    w_fcnt_nxt         = r_frame_cnt;
    w_bricks_reset_nxt = 1'b0;
    w_ball_reset       = 1'b1;
    case (r_state)
      ST_ATTRACT: begin
        if (w_start_ev) begin
          w_state_nxt        = ST_SERVE;
          w_lives_nxt        = 2'(LIVES_INIT);
          w_score_nxt        = '0;
          w_bricks_nxt       = BRICK_W'(NUM_BRICKS);
          w_bricks_reset_nxt = 1'b1;
        end
      end
      ST_SERVE: begin
        if (r_frame_tick) begin
          if (r_frame_cnt == FCNT_W'(SERVE_FRAMES - 1)) begin
            w_state_nxt = ST_PLAY;
          end else begin
            w_fcnt_nxt = r_frame_cnt + FCNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        w_ball_reset = 1'b0;
        // The final brick still scores even when the ball is lost the same cycle
        if (brick_hit) begin
          if (r_score != {SCORE_W{1'b1}}) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
          if (r_bricks_left != '0) begin
            w_bricks_nxt = r_bricks_left - BRICK_W'(1);
          end
        end
        if (brick_hit && (r_bricks_left == BRICK_W'(1))) begin
          w_state_nxt = ST_WON;
        end else if (ball_lost) begin
          if (r_lives != 2'd0) begin
            w_lives_nxt = r_lives - 2'd1;
          end
          w_state_nxt = (r_lives <= 2'd1) ? ST_LOST : ST_SERVE;
        end else if (w_start_ev) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        // Ball frozen in place rather than returned to the serve position
        w_ball_reset = 1'b0;
        if (w_start_ev) begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_WON, ST_LOST: begin
        if (r_frame_tick) begin
          if (r_frame_cnt == FCNT_W'(OVER_FRAMES - 1)) begin
            w_state_nxt = ST_ATTRACT;
          end else begin
            w_fcnt_nxt = r_frame_cnt + FCNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_ATTRACT;
      end
    endcase
    // Every phase starts its frame count from zero
    if (w_state_nxt != r_state) begin
      w_fcnt_nxt = '0;
    end
  end

  // Game counters and the brick-wall restore pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lives        <= 2'd0;
      r_score        <= '0;
      r_bricks_left  <= BRICK_W'(NUM_BRICKS);
      r_frame_cnt    <= '0;
      r_bricks_reset <= 1'b0;
    end else begin
      r_lives        <= w_lives_nxt;
      r_score        <= w_score_nxt;
      r_bricks_left  <= w_bricks_nxt;
      r_frame_cnt    <= w_fcnt_nxt;
      r_bricks_reset <= w_bricks_reset_nxt;
    end
  end

  assign frame_tick   = r_frame_tick;
  assign move_en      = r_frame_tick && (r_state == ST_PLAY);
  assign ball_reset   = w_ball_reset;
  assign bricks_reset = r_bricks_reset;
  assign state        = r_state;
  assign lives        = r_lives;
  assign score        = r_score;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_game_sequencer                                      |
// | Brief   : Directed self-checking bench for game_sequencer.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_game_sequencer;

  localparam int C_FRAME_LINE = 500;
  localparam int C_SCORE_W    = 10;

  logic                 clk;
  logic                 rst_n;
  logic [9:0]           counter_x;
  logic [8:0]           counter_y;
  logic                 btn_start;
  logic                 ball_lost;
  logic                 brick_hit;
  logic                 frame_tick;
  logic                 move_en;
  logic                 ball_reset;
  logic                 bricks_reset;
  logic [2:0]           state;
  logic [1:0]           lives;
  logic [C_SCORE_W-1:0] score;

  int n_cmp = 0;
  int n_err = 0;

  game_sequencer #(
    .FRAME_LINE   (C_FRAME_LINE),
    .LIVES_INIT   (3),
    .NUM_BRICKS   (2),
    .SERVE_FRAMES (2),
    .OVER_FRAMES  (3),
    .SCORE_W      (C_SCORE_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .counter_x    (counter_x),
    .counter_y    (counter_y),
    .btn_start    (btn_start),
    .ball_lost    (ball_lost),
    .brick_hit    (brick_hit),
    .frame_tick   (frame_tick),
    .move_en      (move_en),
    .ball_reset   (ball_reset),
    .bricks_reset (bricks_reset),
    .state        (state),
    .lives        (lives),
    .score        (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame strobe; checks the strobe and the gated move enable
  task automatic do_frame(input logic exp_move);
    counter_x = 10'd0;
    counter_y = 9'(C_FRAME_LINE);
    tick();
    counter_x = 10'd1;
    chk_val("frame_tick", 32'(frame_tick), 32'd1);
    chk_val("move_en", 32'(move_en), 32'(exp_move));
    tick();
  endtask

  // Button held 3 cycles: the phase changes on the third edge
  task automatic press();
    btn_start = 1'b1;
    tick();
    tick();
    tick();
    btn_start = 1'b0;
  endtask

  task automatic serve_to_play();
    do_frame(1'b0);
    chk_val("serve_hold", 32'(state), 32'd1);
    do_frame(1'b0);
    chk_val("play_entry", 32'(state), 32'd2);
    tick();
    tick();
  endtask

  task automatic lose_ball();
    ball_lost = 1'b1;
    tick();
    ball_lost = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    counter_x = 10'd1;
    counter_y = 9'd0;
    btn_start = 1'b0;
    ball_lost = 1'b0;
    brick_hit = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    chk_val("rst_state", 32'(state), 32'd0);
    chk_val("rst_lives", 32'(lives), 32'd0);
    chk_val("rst_score", 32'(score), 32'd0);
    chk_val("rst_ball_reset", 32'(ball_reset), 32'd1);
    chk_val("rst_bricks_reset", 32'(bricks_reset), 32'd0);

    // Attract holds through frames without moving the ball
    do_frame(1'b0);
    do_frame(1'b0);
    chk_val("attract_state", 32'(state), 32'd0);
    chk_val("attract_ball_reset", 32'(ball_reset), 32'd1);

    // Start held 5 cycles: one start, SERVE on third edge
    btn_start = 1'b1;
    tick();
    chk_val("press_lat1", 32'(state), 32'd0);
    tick();
    chk_val("press_lat2", 32'(state), 32'd0);
    tick();
    chk_val("serve_state", 32'(state), 32'd1);
    chk_val("serve_lives", 32'(lives), 32'd3);
    chk_val("serve_score", 32'(score), 32'd0);
    chk_val("bricks_reset_on", 32'(bricks_reset), 32'd1);
    chk_val("serve_ball_reset", 32'(ball_reset), 32'd1);
    tick();
    chk_val("bricks_reset_off", 32'(bricks_reset), 32'd0);
    tick();
    btn_start = 1'b0;
    tick(); tick(); tick();
    chk_val("held_no_repeat", 32'(state), 32'd1);
    chk_val("bricks_reset_once", 32'(bricks_reset), 32'd0);

    serve_to_play();
    chk_val("play_ball_reset", 32'(ball_reset), 32'd0);
    do_frame(1'b1);

    // Three lost balls
    lose_ball();
    chk_val("lost1_state", 32'(state), 32'd1);
    chk_val("lost1_lives", 32'(lives), 32'd2);
    serve_to_play();
    lose_ball();
    chk_val("lost2_state", 32'(state), 32'd1);
    chk_val("lost2_lives", 32'(lives), 32'd1);
    serve_to_play();
    lose_ball();
    chk_val("lost3_state", 32'(state), 32'd5);
    chk_val("lost3_lives", 32'(lives), 32'd0);
    do_frame(1'b0);
    do_frame(1'b0);
    chk_val("over_hold", 32'(state), 32'd5);
    do_frame(1'b0);
    chk_val("over_to_attract", 32'(state), 32'd0);

    // New game, pause/resume
    press();
    chk_val("game2_state", 32'(state), 32'd1);
    chk_val("game2_lives", 32'(lives), 32'd3);
    tick(); tick(); tick();
    serve_to_play();
    press();
    chk_val("pause_state", 32'(state), 32'd3);
    chk_val("pause_ball_reset", 32'(ball_reset), 32'd0);
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    chk_val("pause_no_score", 32'(score), 32'd0);
    do_frame(1'b0);
    chk_val("pause_hold", 32'(state), 32'd3);
    press();
    chk_val("resume_state", 32'(state), 32'd2);
    tick(); tick(); tick();
    do_frame(1'b1);

    // Bricks: second hit coincides with a lost ball, win takes priority
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    chk_val("hit1_score", 32'(score), 32'd1);
    chk_val("hit1_state", 32'(state), 32'd2);
    brick_hit = 1'b1;
    ball_lost = 1'b1;
    tick();
    brick_hit = 1'b0;
    ball_lost = 1'b0;
    chk_val("won_state", 32'(state), 32'd4);
    chk_val("won_score", 32'(score), 32'd2);
    chk_val("won_lives", 32'(lives), 32'd3);
    chk_val("won_ball_reset", 32'(ball_reset), 32'd1);
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    chk_val("won_hit_ignored", 32'(score), 32'd2);
    do_frame(1'b0);
    do_frame(1'b0);
    do_frame(1'b0);
    chk_val("won_to_attract", 32'(state), 32'd0);
    chk_val("attract_score_held", 32'(score), 32'd2);

    // Reset in the middle of play
    press();
    tick(); tick(); tick();
    serve_to_play();
    rst_n = 1'b0;
    tick();
    chk_val("midrst_state", 32'(state), 32'd0);
    chk_val("midrst_lives", 32'(lives), 32'd0);
    chk_val("midrst_ball_reset", 32'(ball_reset), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
